// File: rtl/mips_div_seq.sv
// Iterative radix-2 restoring divider (DIV/DIVU) producing LO (quotient) and HI (remainder).
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the iteration phase.
module mips_div_seq #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int unsigned CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PREP,
      S_ITER,
      S_FIX
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] op_a_q, op_a_d;
   logic [WIDTH-1:0] op_b_q, op_b_d;
   logic             sgn_q, sgn_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             q_neg_q, q_neg_d;
   logic             r_neg_q, r_neg_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rmd_q, rmd_d;
   logic             dz_q, dz_d;

   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   trial;
   logic             a_neg;
   logic             b_neg;

   // Shift the next dividend bit into the partial remainder, then try subtracting.
   assign rem_sh = {rem_q, quo_q[WIDTH-1]};
   assign trial  = rem_sh - {1'b0, dvs_q};

   always_comb begin
      state_d = state_q;
      op_a_d  = op_a_q;
      op_b_d  = op_b_q;
      sgn_d   = sgn_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      cnt_d   = cnt_q;
      q_neg_d = q_neg_q;
      r_neg_d = r_neg_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      quot_d  = quot_q;
      rmd_d   = rmd_q;
      dz_d    = dz_q;
      a_neg   = sgn_q & op_a_q[WIDTH-1];
      b_neg   = sgn_q & op_b_q[WIDTH-1];

      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_a_d  = dividend;
               op_b_d  = divisor;
               sgn_d   = is_signed;
               dz_d    = 1'b0;
               busy_d  = 1'b1;
               state_d = S_PREP;
            end
         end

         S_PREP: begin
            quo_d   = a_neg ? -op_a_q : op_a_q;
            dvs_d   = b_neg ? -op_b_q : op_b_q;
            q_neg_d = a_neg ^ b_neg;
            r_neg_d = a_neg;
            rem_d   = '0;
            cnt_d   = CW'(WIDTH - 1);
            state_d = S_ITER;
`ifdef DIV_ZERO_FAST_EN
            if (op_b_q == '0) begin
               state_d = S_FIX;
            end
`else
`endif
         end

         S_ITER: begin
            if (!trial[WIDTH]) begin
               rem_d = trial[WIDTH-1:0];
               quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
               rem_d = rem_sh[WIDTH-1:0];
               quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               state_d = S_FIX;
            end
         end

         S_FIX: begin
            // A zero divisor overrides whatever the iteration left behind.
            if (op_b_q == '0) begin
               quot_d = '1;
               rmd_d  = op_a_q;
               dz_d   = 1'b1;
            end else begin
               quot_d = q_neg_q ? -quo_q : quo_q;
               rmd_d  = r_neg_q ? -rem_q : rem_q;
            end
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         op_a_q  <= '0;
         op_b_q  <= '0;
         sgn_q   <= 1'b0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         cnt_q   <= '0;
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         quot_q  <= '0;
         rmd_q   <= '0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
         sgn_q   <= sgn_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         cnt_q   <= cnt_d;
         q_neg_q <= q_neg_d;
         r_neg_q <= r_neg_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         quot_q  <= quot_d;
         rmd_q   <= rmd_d;
         dz_q    <= dz_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quot_q;
   assign remainder   = rmd_q;
   assign div_by_zero = dz_q;

endmodule

// File: tb/tb_mips_div_seq.sv
// Scoreboard bench for mips_div_seq: driver pushes expected results, monitor pops on done.
module tb_mips_div_seq;

   localparam int unsigned W   = 32;
   localparam int unsigned LAT = W + 2;
`ifdef DIV_ZERO_FAST_EN
   localparam int unsigned LAT_DZ = 2;
`else
   localparam int unsigned LAT_DZ = W + 2;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic         is_signed;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   mips_div_seq #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .is_signed  (is_signed),
      .dividend   (dividend),
      .divisor    (divisor),
      .busy       (busy),
      .done       (done),
      .quotient   (quotient),
      .remainder  (remainder),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int unsigned  k;
      int unsigned  done_cyc;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
   } exp_t;

   exp_t         sb[$];
   logic [W-1:0] last_q  = '0;
   logic [W-1:0] last_r  = '0;
   logic         last_dz = 1'b0;

   function automatic void chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, req, cyc);
      end
   endfunction

   // Reference model: plain arithmetic on the architectural rules.
   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                 output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
      logic signed [W-1:0] sa, sd, sq, sr;
      dz = 1'b0;
      if (b == '0) begin
         q  = '1;
         r  = a;
         dz = 1'b1;
      end else if (!s) begin
         q = a / b;
         r = a % b;
      end else if (a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
         q = a;
         r = '0;
      end else begin
         sa = a;
         sd = b;
         sq = sa / sd;
         sr = sa % sd;
         q  = sq;
         r  = sr;
      end
   endfunction

   // Monitor: sampled 1 time unit after each rising edge.
   initial begin
      exp_t e;
      logic busy_exp, dz_exp;
      forever begin
         @(posedge clk);
         #1;
         if (done) begin
            if (sb.size() == 0) begin
               chk("spurious_done", {31'b0, done}, '0);
            end else begin
               e = sb.pop_front();
               chk("latency", W'(cyc), W'(e.done_cyc));
               chk("quotient", quotient, e.q);
               chk("remainder", remainder, e.r);
               chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, e.dz});
               last_q  = e.q;
               last_r  = e.r;
               last_dz = e.dz;
            end
         end else if (sb.size() > 0 && cyc >= sb[0].done_cyc) begin
            chk("done_timeout", {31'b0, done}, 32'd1);
            e       = sb.pop_front();
            last_q  = e.q;
            last_r  = e.r;
            last_dz = e.dz;
         end
         busy_exp = (sb.size() > 0) && (cyc >= sb[0].k) && (cyc < sb[0].done_cyc);
         dz_exp   = ((sb.size() > 0) && (cyc >= sb[0].k)) ? 1'b0 : last_dz;
         chk("busy", {31'b0, busy}, {31'b0, busy_exp});
         chk("dz_hold", {31'b0, div_by_zero}, {31'b0, dz_exp});
         if (!done) begin
            chk("quotient_hold", quotient, last_q);
            chk("remainder_hold", remainder, last_r);
         end
      end
   end

   // Called at a falling edge; the start is sampled at the next rising edge.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
      exp_t e;
      start     = 1'b1;
      dividend  = a;
      divisor   = b;
      is_signed = s;
      e.k        = cyc + 1;
      e.done_cyc = e.k + ((b == '0) ? LAT_DZ : LAT);
      e.q        = eq;
      e.r        = er;
      e.dz       = edz;
      sb.push_back(e);
      @(negedge clk);
      start     = 1'b0;
      dividend  = $urandom;
      divisor   = $urandom;
      is_signed = 1'($urandom_range(0, 1));
   endtask

   task automatic issue_rand(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      logic [W-1:0] q, r;
      logic         dz;
      model(a, b, s, q, r, dz);
      issue(a, b, s, q, r, dz);
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!done) chk("wait_done", {31'b0, done}, 32'd1);
   endtask

   task automatic check_reset_outputs();
      chk("rst_busy", {31'b0, busy}, '0);
      chk("rst_done", {31'b0, done}, '0);
      chk("rst_quotient", quotient, '0);
      chk("rst_remainder", remainder, '0);
      chk("rst_dz", {31'b0, div_by_zero}, '0);
   endtask

   initial begin
      logic [W-1:0] a, b;
      int unsigned  sel;
      rst_n     = 1'b0;
      start     = 1'b0;
      is_signed = 1'b0;
      dividend  = '0;
      divisor   = '0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed cases, issued back-to-back in each done cycle.
      issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
      wait_done();
      issue(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
      wait_done();
      issue(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0);
      wait_done();
      issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0);
      wait_done();
      issue(32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0);
      wait_done();
      issue(32'h1234_5678, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
      wait_done();
      issue(32'h8765_4321, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h8765_4321, 1'b1);
      wait_done();
      repeat (3) @(negedge clk);

      // A second start mid-operation must be ignored.
      issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
      repeat (9) @(negedge clk);
      start     = 1'b1;
      dividend  = 32'd50;
      divisor   = 32'd5;
      is_signed = 1'b0;
      @(negedge clk);
      start = 1'b0;
      wait_done();

      // Reset mid-operation aborts with no done.
      issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
      repeat (14) @(negedge clk);
      rst_n = 1'b0;
      sb.delete();
      last_q  = '0;
      last_r  = '0;
      last_dz = 1'b0;
      @(posedge clk);
      #1;
      check_reset_outputs();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
      wait_done();

      // Randomised operations with biased divisor classes and random gaps.
      for (int i = 0; i < 300; i++) begin
         sel = $urandom_range(0, 9);
         a   = $urandom;
         b   = $urandom >> $urandom_range(0, 31);
         if (sel == 0) b = '0;
         else if (sel <= 3) b = W'($urandom_range(1, 15));
         else if (sel == 4) begin
            a = 32'h8000_0000;
            b = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'd1;
         end else if (sel == 5) a = a >> $urandom_range(0, 31);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         issue_rand(a, b, 1'($urandom_range(0, 1)));
         wait_done();
      end

      repeat (5) @(negedge clk);
      chk("scoreboard_drain", W'(sb.size()), '0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
